// File: rtl/robo_sensores.sv
// robo_sensores: robot grid position/heading plus a four-step map read that refreshes the
// head/left/under/barrier sensors. Define MAP_TORUS_EN to make the grid wrap at its edges.
module robo_sensores #(
    parameter int MAP_W   = 16,
    parameter int MAP_H   = 12,
    parameter int ADDR_W  = 8,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              avancar,
    input  logic              girar,
    input  logic              recolher_entulho,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [1:0]        map_rdata,
    output logic              map_we,
    output logic [1:0]        map_wdata,
    output logic              head,
    output logic              left,
    output logic              under,
    output logic              barrier,
    output logic [ADDR_W-1:0] pos_x,
    output logic [ADDR_W-1:0] pos_y,
    output logic [1:0]        dir,
    output logic              busy,
    output logic              cmd_drop,
    output logic [7:0]        entulho_cnt
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EXEC  = 3'd1;
    localparam logic [2:0] A_U   = 3'd2;
    localparam logic [2:0] A_H   = 3'd3;
    localparam logic [2:0] A_L   = 3'd4;
    localparam logic [2:0] CAP_L = 3'd5;

    localparam logic [1:0] CMD_NONE     = 2'd0;
    localparam logic [1:0] CMD_AVANCAR  = 2'd1;
    localparam logic [1:0] CMD_GIRAR    = 2'd2;
    localparam logic [1:0] CMD_RECOLHER = 2'd3;

    localparam logic [1:0] CELL_WALL    = 2'b01;
    localparam logic [1:0] CELL_DEBRIS  = 2'b10;
    localparam logic [1:0] CELL_BARRIER = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] posX_q, posX_d;
    logic [ADDR_W-1:0] posY_q, posY_d;
    logic [1:0]        dir_q, dir_d;
    logic              head_q, head_d;
    logic              left_q, left_d;
    logic              under_q, under_d;
    logic              barrier_q, barrier_d;
    logic              underStage_q, underStage_d;
    logic [1:0]        aheadStage_q, aheadStage_d;
    logic              cmdDrop_q, cmdDrop_d;
    logic [7:0]        entulhoCnt_q, entulhoCnt_d;

    logic [ADDR_W-1:0] aheadX, aheadY, leftX, leftY;
    logic [ADDR_W-1:0] selX, selY;
    logic              aheadOob, leftOob;
    logic              anyPulse;

    // Neighbour one step in heading d; wrapped coordinates are always produced, and
    // the off-grid flag is suppressed when the grid is a torus.
    function automatic void stepCell(
        input  logic [ADDR_W-1:0] x,
        input  logic [ADDR_W-1:0] y,
        input  logic [1:0]        d,
        output logic [ADDR_W-1:0] nx,
        output logic [ADDR_W-1:0] ny,
        output logic              oob
    );
        nx  = x;
        ny  = y;
        oob = 1'b0;
        case (d)
            2'd0: begin
                if (y == '0) begin
                    oob = 1'b1;
                    ny  = ADDR_W'(MAP_H - 1);
                end else begin
                    ny = y - ADDR_W'(1);
                end
            end
            2'd1: begin
                if (x == ADDR_W'(MAP_W - 1)) begin
                    oob = 1'b1;
                    nx  = '0;
                end else begin
                    nx = x + ADDR_W'(1);
                end
            end
            2'd2: begin
                if (y == ADDR_W'(MAP_H - 1)) begin
                    oob = 1'b1;
                    ny  = '0;
                end else begin
                    ny = y + ADDR_W'(1);
                end
            end
            default: begin
                if (x == '0) begin
                    oob = 1'b1;
                    nx  = ADDR_W'(MAP_W - 1);
                end else begin
                    nx = x - ADDR_W'(1);
                end
            end
        endcase
`ifdef MAP_TORUS_EN
        oob = 1'b0;
`endif
    endfunction

    always_comb begin
        stepCell(posX_q, posY_q, dir_q, aheadX, aheadY, aheadOob);
        stepCell(posX_q, posY_q, dir_q + 2'd3, leftX, leftY, leftOob);
    end

    // Off-grid neighbours are never read; the current cell is addressed instead.
    always_comb begin
        selX = posX_q;
        selY = posY_q;
        if (state_q == A_H && !aheadOob) begin
            selX = aheadX;
            selY = aheadY;
        end else if (state_q == A_L && !leftOob) begin
            selX = leftX;
            selY = leftY;
        end
        map_addr = reset ? (selY * ADDR_W'(MAP_W) + selX) : '0;
    end

    assign anyPulse  = avancar | girar | recolher_entulho;
    assign map_we    = (state_q == EXEC) && (cmd_q == CMD_RECOLHER) && under_q;
    assign map_wdata = 2'b00;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        posX_d       = posX_q;
        posY_d       = posY_q;
        dir_d        = dir_q;
        head_d       = head_q;
        left_d       = left_q;
        under_d      = under_q;
        barrier_d    = barrier_q;
        underStage_d = underStage_q;
        aheadStage_d = aheadStage_q;
        cmdDrop_d    = cmdDrop_q;
        entulhoCnt_d = entulhoCnt_q;

        case (state_q)
            IDLE: begin
                if (anyPulse) begin
                    state_d = EXEC;
                    if (recolher_entulho) begin
                        cmd_d = CMD_RECOLHER;
                    end else if (girar) begin
                        cmd_d = CMD_GIRAR;
                    end else begin
                        cmd_d = CMD_AVANCAR;
                    end
                end
            end
            EXEC: begin
                state_d = A_U;
                case (cmd_q)
                    CMD_AVANCAR: begin
                        if (!head_q && !barrier_q) begin
                            posX_d = aheadX;
                            posY_d = aheadY;
                        end
                    end
                    CMD_GIRAR: dir_d = dir_q + 2'd1;
                    CMD_RECOLHER: begin
                        if (under_q && entulhoCnt_q != 8'hFF) begin
                            entulhoCnt_d = entulhoCnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
            A_U: state_d = A_H;
            A_H: begin
                underStage_d = (map_rdata == CELL_DEBRIS);
                state_d      = A_L;
            end
            A_L: begin
                aheadStage_d = aheadOob ? CELL_WALL : map_rdata;
                state_d      = CAP_L;
            end
            CAP_L: begin
                head_d    = (aheadStage_q == CELL_WALL);
                barrier_d = (aheadStage_q == CELL_BARRIER);
                under_d   = underStage_q;
                left_d    = leftOob ? 1'b1 : (map_rdata == CELL_WALL);
                state_d   = IDLE;
            end
            default: state_d = A_U;
        endcase

        if (state_q != IDLE && anyPulse) begin
            cmdDrop_d = 1'b1;
        end
    end

    // Reset lands in A_U so the sensors are refreshed straight out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= A_U;
            cmd_q        <= CMD_NONE;
            posX_q       <= ADDR_W'(START_X);
            posY_q       <= ADDR_W'(START_Y);
            dir_q        <= 2'd0;
            head_q       <= 1'b0;
            left_q       <= 1'b0;
            under_q      <= 1'b0;
            barrier_q    <= 1'b0;
            underStage_q <= 1'b0;
            aheadStage_q <= 2'b00;
            cmdDrop_q    <= 1'b0;
            entulhoCnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            posX_q       <= posX_d;
            posY_q       <= posY_d;
            dir_q        <= dir_d;
            head_q       <= head_d;
            left_q       <= left_d;
            under_q      <= under_d;
            barrier_q    <= barrier_d;
            underStage_q <= underStage_d;
            aheadStage_q <= aheadStage_d;
            cmdDrop_q    <= cmdDrop_d;
            entulhoCnt_q <= entulhoCnt_d;
        end
    end

    assign head        = head_q;
    assign left        = left_q;
    assign under       = under_q;
    assign barrier     = barrier_q;
    assign pos_x       = posX_q;
    assign pos_y       = posY_q;
    assign dir         = dir_q;
    assign busy        = (state_q != IDLE);
    assign cmd_drop    = cmdDrop_q;
    assign entulho_cnt = entulhoCnt_q;

endmodule

// File: tb/tb_robo_sensores.sv
// tb_robo_sensores: random and directed commands against a cell-map RAM, checked every cycle
// against a command-level model of the robot; MAP_TORUS_EN selects the wrapping-grid rules.
module tb_robo_sensores;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          avancar = 1'b0;
    logic          girar = 1'b0;
    logic          recolher_entulho = 1'b0;
    logic [AW-1:0] map_addr;
    logic [1:0]    map_rdata = 2'b00;
    logic          map_we;
    logic [1:0]    map_wdata;
    logic          head, left, under, barrier;
    logic [AW-1:0] pos_x, pos_y;
    logic [1:0]    dir;
    logic          busy, cmd_drop;
    logic [7:0]    entulho_cnt;

    logic [1:0] ram    [0:255];
    logic [1:0] refMap [0:255];

    int testsRun    = 0;
    int testsFailed = 0;

    int   mX, mY, mDir, mPend, mCmd, mCnt;
    logic mHead, mLeft, mUnder, mBarrier, mDrop;
    int   dxTab [4] = '{0, 1, 0, -1};
    int   dyTab [4] = '{-1, 0, 1, 0};

    robo_sensores #(.MAP_W(W), .MAP_H(H), .ADDR_W(AW), .START_X(0), .START_Y(0)) dut (
        .clock(clock), .reset(reset),
        .avancar(avancar), .girar(girar), .recolher_entulho(recolher_entulho),
        .map_addr(map_addr), .map_rdata(map_rdata), .map_we(map_we), .map_wdata(map_wdata),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
        .busy(busy), .cmd_drop(cmd_drop), .entulho_cnt(entulho_cnt)
    );

    always #10 clock = ~clock;

    // Synchronous single-port map RAM: read data appears one cycle after the address.
    initial begin
        logic [1:0] rd;
        forever begin
            @(posedge clock);
            rd = ram[map_addr];
            if (map_we) ram[map_addr] = map_wdata;
            map_rdata <= rd;
        end
    end

    function automatic int wrapC(input int v, input int n);
        return ((v % n) + n) % n;
    endfunction

    function automatic logic [1:0] cellAt(input int x, input int y);
`ifdef MAP_TORUS_EN
        return refMap[wrapC(y, H) * W + wrapC(x, W)];
`else
        if (x < 0 || x >= W || y < 0 || y >= H) return 2'b01;
        return refMap[y * W + x];
`endif
    endfunction

    task automatic modelReset();
        mX = 0; mY = 0; mDir = 0; mPend = 4; mCmd = 0; mCnt = 0;
        mHead = 1'b0; mLeft = 1'b0; mUnder = 1'b0; mBarrier = 1'b0; mDrop = 1'b0;
    endtask

    // Command-level model: mPend counts the busy cycles left; the command acts on the
    // first of them and the sensors are re-read from the map on the last one.
    task automatic modelStep();
        logic anyP;
        logic [1:0] ahead;
        int ld;
        anyP = avancar | girar | recolher_entulho;
        if (mPend != 0) begin
            if (anyP) mDrop = 1'b1;
            if (mPend == 5) begin
                case (mCmd)
                    1: if (!mHead && !mBarrier) begin
                        mX = wrapC(mX + dxTab[mDir], W);
                        mY = wrapC(mY + dyTab[mDir], H);
                    end
                    2: mDir = (mDir + 1) % 4;
                    3: if (mUnder) begin
                        refMap[mY * W + mX] = 2'b00;
                        if (mCnt < 255) mCnt++;
                    end
                    default: ;
                endcase
            end
            if (mPend == 1) begin
                ld       = (mDir + 3) % 4;
                ahead    = cellAt(mX + dxTab[mDir], mY + dyTab[mDir]);
                mUnder   = (cellAt(mX, mY) == 2'b10);
                mHead    = (ahead == 2'b01);
                mBarrier = (ahead == 2'b11);
                mLeft    = (cellAt(mX + dxTab[ld], mY + dyTab[ld]) == 2'b01);
            end
            mPend--;
        end else if (anyP) begin
            mCmd  = recolher_entulho ? 3 : (girar ? 2 : 1);
            mPend = 5;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) modelReset();
            else modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    initial begin
        logic [63:0] gotVec, expVec;
        logic expWe;
        forever begin
            @(negedge clock);
            expWe  = reset && (mPend == 5) && (mCmd == 3) && mUnder;
            gotVec = 64'({busy, pos_x, pos_y, dir, head, left, under, barrier,
                          cmd_drop, entulho_cnt, map_we});
            expVec = 64'({mPend != 0, 8'(mX), 8'(mY), 2'(mDir), mHead, mLeft, mUnder,
                          mBarrier, mDrop, 8'(mCnt), expWe});
            checkOutput("cycle outputs", gotVec, expVec);
            if (expWe) checkOutput("write addr/data", 64'({map_addr, map_wdata}),
                                   64'({8'(mY * W + mX), 2'b00}));
            if (!reset) checkOutput("reset map_addr", 64'(map_addr), 64'd0);
        end
    end

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // kind 0: all free; 1: debris at (0,0), barrier at (1,0); 2: random cells.
    task automatic applyReset(input int kind);
        int r;
        @(posedge clock); #1;
        avancar = 1'b0; girar = 1'b0; recolher_entulho = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 9);
            if (kind == 2) ram[i] = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            else ram[i] = 2'b00;
            refMap[i] = ram[i];
        end
        if (kind == 1) begin
            ram[0] = 2'b10; refMap[0] = 2'b10;
            ram[1] = 2'b11; refMap[1] = 2'b11;
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic applyStimulus(input logic a, input logic g, input logic r);
        @(posedge clock); #1;
        avancar = a; girar = g; recolher_entulho = r;
        @(posedge clock); #1;
        avancar = 1'b0; girar = 1'b0; recolher_entulho = 1'b0;
    endtask

    initial begin
        logic [2:0] p;
`ifndef MAP_TORUS_EN
        applyReset(0);
        checkOutput("busy right after release", 64'(busy), 64'd1);
        waitNeg(4);
        checkOutput("busy in 4th refresh cycle", 64'(busy), 64'd1);
        waitNeg(1);
        checkOutput("busy after refresh", 64'(busy), 64'd0);
        checkOutput("sensors at origin N", 64'({head, left, under, barrier}), 64'(4'b1100));

        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(1);
        checkOutput("dir at N+1", 64'(dir), 64'd0);
        waitNeg(1);
        checkOutput("dir at N+2", 64'(dir), 64'd1);
        waitNeg(3);
        checkOutput("busy at N+5", 64'({busy, head}), 64'(2'b11));
        waitNeg(1);
        checkOutput("girar sensors at N+6", 64'({busy, head, left}), 64'(3'b001));

        applyReset(1);
        waitNeg(5);
        checkOutput("debris start sensors", 64'({head, left, under, barrier}), 64'(4'b1110));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(6);
        checkOutput("barrier ahead E", 64'({head, under, barrier}), 64'(3'b011));
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(1);
        checkOutput("blocked move no write", 64'(map_we), 64'd0);
        waitNeg(5);
        checkOutput("blocked move pos_x", 64'({busy, pos_x}), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(1);
        checkOutput("clear write strobe", 64'({map_we, map_addr, map_wdata}), 64'({1'b1, 8'd0, 2'b00}));
        waitNeg(1);
        checkOutput("entulho_cnt at N+2", 64'(entulho_cnt), 64'd1);
        waitNeg(4);
        checkOutput("under after clear", 64'({under, barrier, entulho_cnt}), 64'({1'b0, 1'b1, 8'd1}));

        applyStimulus(1'b0, 1'b1, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1 avancar = 1'b1;
        @(posedge clock); #1 avancar = 1'b0;
        waitNeg(1);
        checkOutput("cmd_drop after busy pulse", 64'(cmd_drop), 64'd1);
        waitNeg(2);
        checkOutput("dropped avancar ignored", 64'({busy, dir, pos_x, pos_y}), 64'({1'b0, 2'd2, 8'd0, 8'd0}));
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(6);
        checkOutput("girar beats avancar", 64'({dir, pos_x, pos_y, cmd_drop}), 64'({2'd3, 8'd0, 8'd0, 1'b1}));
`else
        applyReset(0);
        waitNeg(5);
        checkOutput("torus sensors at origin", 64'({head, left, under, barrier}), 64'(4'b0000));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            waitNeg(6);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(6);
        checkOutput("torus wrap west", 64'({pos_x, pos_y, dir}), 64'({8'd15, 8'd0, 2'd3}));
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            waitNeg(6);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(6);
        checkOutput("torus wrap east", 64'({pos_x, pos_y, dir}), 64'({8'd0, 8'd0, 2'd1}));
`endif

        for (int blk = 0; blk < 6; blk++) begin
            applyReset(2);
            for (int c = 0; c < 400; c++) begin
                @(posedge clock); #1;
                p = 3'b000;
                if (blk % 2 == 0) begin
                    if (mPend == 0 && $urandom_range(0, 99) < 40) p = 3'($urandom_range(1, 7));
                end else if ($urandom_range(0, 99) < 15) begin
                    p = 3'($urandom_range(1, 7));
                end
                {avancar, girar, recolher_entulho} = p;
            end
        end
        @(posedge clock); #1;
        {avancar, girar, recolher_entulho} = 3'b000;
        waitNeg(8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/robo_sensores.md
# robo_sensores

Environment and sensor model for the cleaning robot. It holds the robot's grid position and heading, and applies the `avancar`, `girar` and `recolher_entulho` command pulses produced by the robot controller. It reads the cell map through a synchronous single-port RAM and drives the `head`, `left`, `under` and `barrier` sensor inputs back into that controller. It also exports position and heading for the sprite/VGA stage.

## Interface
Parameters:
- MAP_W, 16, grid width in cells
- MAP_H, 12, grid height in cells
- ADDR_W, 8, map address width; must satisfy 2^ADDR_W ≥ MAP_W*MAP_H
- START_X, 0, column after reset
- START_Y, 0, row after reset

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- avancar  in  1  one-cycle pulse: move forward one cell
- girar  in  1  one-cycle pulse: rotate 90° clockwise
- recolher_entulho  in  1  one-cycle pulse: clear debris in current cell
- map_addr  out  ADDR_W  RAM address, computed as y*MAP_W + x
- map_rdata  in  2  RAM read data, valid one cycle after the address is driven
- map_we  out  1  RAM write strobe
- map_wdata  out  2  RAM write data, always 2'b00
- head  out  1  cell ahead is a wall (01)
- left  out  1  cell to the left is a wall (01)
- under  out  1  current cell holds debris (10)
- barrier  out  1  cell ahead is a barrier (11)
- pos_x  out  ADDR_W  current column
- pos_y  out  ADDR_W  current row
- dir  out  2  heading: 0=N, 1=E, 2=S, 3=W
- busy  out  1  command or sensor refresh in progress
- cmd_drop  out  1  sticky: a command arrived while busy
- entulho_cnt  out  8  debris cells cleared, saturating at 255

## Operation
- Cell encoding: 00 free, 01 wall, 10 debris, 11 barrier.
- FSM states: IDLE, EXEC, A_U, A_H, A_L, CAP_L.
- In IDLE, a command is accepted on any cycle where one or more pulses are high.
  - Priority when pulses coincide: recolher_entulho, then girar, then avancar. Only one command executes; the lower-priority pulses are discarded without setting cmd_drop.
- EXEC, by accepted command:
  - avancar: move one cell in `dir` only if the published head=0 and barrier=0. Otherwise the position is unchanged.
  - girar: dir ← dir+1 (mod 4).
  - recolher_entulho: only if under=1, drive map_we=1 with map_addr set to the current cell, and increment entulho_cnt (saturating).
- Sensor refresh:
  - A_U drives the address of the current cell.
  - A_H captures under and drives the address of the cell ahead.
  - A_L captures the head/barrier source and drives the address of the left cell.
  - CAP_L captures left.
  - All four sensors publish simultaneously at the end of CAP_L, then the FSM returns to IDLE.
- Out-of-bounds neighbour: no RAM read is issued; the captured value is forced to 01 (wall).
- Moves never leave the grid, because a blocked move is refused.
- Any pulse arriving in a state other than IDLE is ignored and sets cmd_drop. cmd_drop clears only on reset.

## Timing
- Reset values:
  - pos_x=START_X, pos_y=START_Y, dir=0
  - head, left, under, barrier = 0
  - busy=1, map_we=0, map_addr=0, cmd_drop=0, entulho_cnt=0
  - FSM state = A_U, so a refresh runs automatically after reset. busy falls 4 cycles after reset release.
- Command sampled in IDLE at cycle N:
  - busy=1 from N+1 through N+5.
  - map_we (if any) high only in N+1.
  - pos_x, pos_y, dir update at the end of N+1.
  - Sensors change at the end of N+5.
  - busy=0 at N+6. The next command is accepted at N+6.
- Sensor outputs never glitch mid-refresh; they hold their previous values until publish.
- Reset asserted mid-refresh aborts the refresh immediately; all outputs take their reset values.

## Configuration
- MAP_TORUS_EN defined: the grid wraps.
  - Neighbours off an edge address the opposite edge (mod MAP_W / MAP_H).
  - avancar across an edge wraps the position.
  - No forced-wall substitution occurs.
- MAP_TORUS_EN undefined: edges behave as walls, as described in Operation.

## Test plan
- Reset with an all-free map → busy falls 4 cycles after release; at (0,0) facing N: head=1, left=1, under=0, barrier=0.
- At (0,0) with dir=0, pulse girar → dir=1 at N+2; busy clears at N+6; head reflects cell (1,0); left=1 (row −1 is out of bounds).
- Cell (1,0)=11 and dir=E, pulse avancar → barrier=1; pos_x stays 0; no map_we.
- Cell (0,0)=10, pulse recolher_entulho → map_we=1 with map_addr=0 and map_wdata=00 at N+1; entulho_cnt=1; under=0 after the RAM returns 00.
- Pulse avancar at N+3 during a refresh → ignored; cmd_drop=1 and stays 1 until reset. Simultaneous girar+avancar in IDLE → only dir changes.
- With MAP_TORUS_EN, at (15,0) facing E with cell (0,0) free, pulse avancar → pos_x=0.
